fib_seq_checker: RTL and testbench

Consumer end of the fibonacci generator stream. Accepts a sample stream over a valid/ready handshake and checks the recurrence x[n] = x[n-1] + x[n-2] mod 2^WIDTH. Reports lock, mismatches and a match count. Sits downstream of the fibonacci block, or of any link carrying its output, as a self-checking monitor.

---
 rtl/fib_pkg.sv | 19 +
 rtl/fib_hist_reg.sv | 42 ++++
 rtl/fib_seq_checker.sv | 137 +++++++++++++
 tb/tb_fib_seq_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the fibonacci generator/checker pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fib_pkg;

  localparam int FIB_WIDTH = 16;

  // Reset values of the generator; a stream from reset begins with these two samples.
  localparam int FIB_SEED0 = 0;
  localparam int FIB_SEED1 = 1;

  typedef enum logic [1:0] {
    SEED0,
    SEED1,
    TRACK,
    FAIL
  } fib_state_t;

endpackage

// File: rtl/fib_hist_reg.sv
// Two-deep sample history (a1 newest, a2 older) with a sum of a1 and the incoming sample.
// Latency: a1/a2 update one cycle after an enable; sum is combinational.
// Backpressure: none; the caller qualifies every enable with an accept.
module fib_hist_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_a2,
  input  logic             wr_a1,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] a1;

  // History update: a shift ages a1 into a2; otherwise each slot may be loaded directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0;
      a2 <= '0;
    end else if (clr) begin
      a1 <= '0;
      a2 <= '0;
    end else if (shift) begin
      a2 <= a1;
      a1 <= d;
    end else begin
      if (wr_a1) a1 <= d;
      if (wr_a2) a2 <= d;
    end
  end

  // Wrapping sum matches the generator's adder.
  always_comb begin
    sum = a1 + d;
  end

endmodule

// File: rtl/fib_seq_checker.sv
// Monitors a sample stream and checks x[n] = x[n-1] + x[n-2] mod 2^WIDTH.
// Latency: all outputs registered, one cycle after an accept.
// Backpressure: in_ready drops only in FAIL (after a halting mismatch); otherwise always ready.
module fib_seq_checker
  import fib_pkg::*;
#(
  parameter int WIDTH       = FIB_WIDTH,
  parameter bit CHECK_SEED  = 1'b1,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err,
  output logic             err_pulse,
  output logic [WIDTH-1:0] exp_data,
  output logic [WIDTH-1:0] count
);

  fib_state_t       state, state_nxt;
  logic             acc;
  logic             mis;
  logic [WIDTH-1:0] miss_exp;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] sum_a1;
  logic [WIDTH-1:0] sum_a2;
  logic             wr_a2, wr_a1, shift;
  // Set once a non-halting mismatch re-seeds from live data; the fixed seed values
  // only apply to the first two samples after reset/clr.
  logic             reseeded;
  logic             seed_chk;

  fib_hist_reg #(.WIDTH(WIDTH)) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .wr_a2 (wr_a2),
    .wr_a1 (wr_a1),
    .shift (shift),
    .d     (in_data),
    .a2    (a2),
    .sum   (sum_a1)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= SEED0;
    else if (clr) state <= SEED0;
    else          state <= state_nxt;
  end

  // Compare the accepted sample against what the current state expects, and pick the next state.
  always_comb begin
    seed_chk  = CHECK_SEED && !reseeded;
    mis       = 1'b0;
    miss_exp  = exp_data;
    state_nxt = state;
    case (state)
      SEED0: begin
        mis      = seed_chk && (in_data != WIDTH'(FIB_SEED0));
        miss_exp = WIDTH'(FIB_SEED0);
      end
      SEED1: begin
        mis      = seed_chk && (in_data != WIDTH'(FIB_SEED1));
        miss_exp = WIDTH'(FIB_SEED1);
      end
      TRACK: begin
        mis      = (in_data != exp_data);
        miss_exp = exp_data;
      end
      default: begin
        mis      = 1'b0;
        miss_exp = exp_data;
      end
    endcase
    if (acc) begin
      if (mis) begin
        state_nxt = HALT_ON_ERR ? FAIL : SEED1;
      end else begin
        case (state)
          SEED0:   state_nxt = SEED1;
          SEED1:   state_nxt = TRACK;
          TRACK:   state_nxt = TRACK;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // Handshake and history enables; in_ready depends on state only.
  always_comb begin
    in_ready = (state != FAIL);
    acc      = in_valid && in_ready;
    sum_a2   = a2 + in_data;
    wr_a2    = acc && ((state == SEED0) || (mis && !HALT_ON_ERR));
    wr_a1    = acc && (state == SEED1) && !mis;
    shift    = acc && (state == TRACK) && !mis;
  end

  // Registered flags, expected value and saturating match count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked    <= 1'b0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      exp_data  <= '0;
      count     <= '0;
      reseeded  <= 1'b0;
    end else if (clr) begin
      locked    <= 1'b0;
      err       <= 1'b0;
      err_pulse <= 1'b0;
      exp_data  <= '0;
      count     <= '0;
      reseeded  <= 1'b0;
    end else begin
      err_pulse <= acc && mis;
      if (acc && mis) begin
        err      <= 1'b1;
        locked   <= 1'b0;
        exp_data <= miss_exp;
        if (!HALT_ON_ERR) reseeded <= 1'b1;
      end else if (acc && (state == SEED1)) begin
        exp_data <= sum_a2;
      end else if (acc && (state == TRACK)) begin
        exp_data <= sum_a1;
        locked   <= 1'b1;
        if (count != {WIDTH{1'b1}}) count <= count + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_checker.sv
module tb_fib_seq_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;

  int checks = 0;
  int failures = 0;

  // default instance: CHECK_SEED=1, HALT_ON_ERR=1
  logic d_rdy, d_lock, d_err, d_pulse;
  logic [15:0] d_exp, d_cnt;
  // no seed check
  logic s_rdy, s_lock, s_err, s_pulse;
  logic [15:0] s_exp, s_cnt;
  // non-halting
  logic h_rdy, h_lock, h_err, h_pulse;
  logic [15:0] h_exp, h_cnt;
  // 4-bit, for count saturation
  logic w_rdy, w_lock, w_err, w_pulse;
  logic [3:0] w_exp, w_cnt;

  always #5 clk = ~clk;

  fib_seq_checker u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(d_rdy), .in_data(in_data),
    .locked(d_lock), .err(d_err), .err_pulse(d_pulse), .exp_data(d_exp), .count(d_cnt)
  );

  fib_seq_checker #(.WIDTH(16), .CHECK_SEED(1'b0), .HALT_ON_ERR(1'b1)) u_ns (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(s_rdy), .in_data(in_data),
    .locked(s_lock), .err(s_err), .err_pulse(s_pulse), .exp_data(s_exp), .count(s_cnt)
  );

  fib_seq_checker #(.WIDTH(16), .CHECK_SEED(1'b1), .HALT_ON_ERR(1'b0)) u_nh (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(h_rdy), .in_data(in_data),
    .locked(h_lock), .err(h_err), .err_pulse(h_pulse), .exp_data(h_exp), .count(h_cnt)
  );

  fib_seq_checker #(.WIDTH(4), .CHECK_SEED(1'b1), .HALT_ON_ERR(1'b1)) u_w4 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(w_rdy), .in_data(in_data[3:0]),
    .locked(w_lock), .err(w_err), .err_pulse(w_pulse), .exp_data(w_exp), .count(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // one accept-capable cycle with a valid sample; outputs sampled 1 time unit after the edge
  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic [15:0] junk);
    in_valid = 1'b0;
    in_data  = junk;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    int npulse;
    logic [3:0] x0, x1, xn;
    logic [15:0] nh_seq [7];
    nh_seq = '{16'd0, 16'd1, 16'd1, 16'd9, 16'd2, 16'd11, 16'd13};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", d_lock, 0);
    chk("rst_err", d_err, 0);
    chk("rst_pulse", d_pulse, 0);
    chk("rst_exp", d_exp, 0);
    chk("rst_count", d_cnt, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_ready", d_rdy, 1);

    // nominal stream
    send(16'd0);
    send(16'd1);
    chk("nom_unlocked_after_seeds", d_lock, 0);
    chk("nom_exp_after_seeds", d_exp, 1);
    send(16'd1);
    chk("nom_locked_third", d_lock, 1);
    send(16'd2);
    send(16'd3);
    send(16'd5);
    send(16'd8);
    chk("nom_count", d_cnt, 5);
    chk("nom_err", d_err, 0);
    chk("nom_exp", d_exp, 13);
    chk("nom_locked", d_lock, 1);

    // backpressure / idle
    do_clr();
    in_valid = 1'b1; in_data = 16'd0; @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'd77; @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'd1; @(posedge clk); #1;
    idle(3, 16'd999);
    chk("bp_exp", d_exp, 1);
    chk("bp_count", d_cnt, 0);
    chk("bp_err", d_err, 0);
    send(16'd1);
    idle(2, 16'd5);
    chk("bp_count_idle", d_cnt, 1);
    chk("bp_exp_idle", d_exp, 2);

    // wrap-around without seed check
    do_clr();
    send(16'd28657);
    send(16'd46368);
    chk("wrap_exp_seed", s_exp, 9489);
    send(16'd9489);
    send(16'd55857);
    chk("wrap_err", s_err, 0);
    chk("wrap_count", s_cnt, 2);
    chk("wrap_exp", s_exp, 65346);
    chk("wrap_locked", s_lock, 1);

    // halting mismatch
    do_clr();
    send(16'd0);
    send(16'd1);
    send(16'd1);
    send(16'd2);
    send(16'd4);
    chk("halt_pulse", d_pulse, 1);
    chk("halt_err", d_err, 1);
    chk("halt_exp", d_exp, 3);
    chk("halt_count", d_cnt, 2);
    chk("halt_ready", d_rdy, 0);
    chk("halt_locked", d_lock, 0);
    idle(1, 16'd0);
    chk("halt_pulse_one_cycle", d_pulse, 0);
    send(16'd3);
    chk("halt_ignore_count", d_cnt, 2);
    chk("halt_ignore_exp", d_exp, 3);
    chk("halt_ignore_pulse", d_pulse, 0);
    chk("halt_ignore_ready", d_rdy, 0);
    do_clr();
    chk("halt_clr_ready", d_rdy, 1);
    chk("halt_clr_err", d_err, 0);
    chk("halt_clr_count", d_cnt, 0);
    send(16'd0);
    send(16'd1);
    send(16'd1);
    chk("halt_clr_restart_count", d_cnt, 1);

    // bad seeds
    do_clr();
    send(16'd5);
    chk("bad_seed0_err", d_err, 1);
    chk("bad_seed0_exp", d_exp, 0);
    chk("bad_seed0_ready", d_rdy, 0);
    do_clr();
    send(16'd0);
    send(16'd2);
    chk("bad_seed1_err", d_err, 1);
    chk("bad_seed1_exp", d_exp, 1);

    // non-halting mismatch and re-seed
    do_clr();
    npulse = 0;
    for (int i = 0; i < 7; i++) begin
      send(nh_seq[i]);
      npulse += int'(h_pulse);
      if (i == 3) chk("nh_pulse_at_9", h_pulse, 1);
    end
    chk("nh_pulses", npulse, 1);
    chk("nh_count", h_cnt, 3);
    chk("nh_exp", h_exp, 24);
    chk("nh_err", h_err, 1);
    chk("nh_locked", h_lock, 1);
    chk("nh_ready", h_rdy, 1);

    // clr beats an accept
    do_clr();
    send(16'd0);
    send(16'd1);
    send(16'd1);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'd2;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_acc_count", d_cnt, 0);
    chk("clr_acc_locked", d_lock, 0);
    chk("clr_acc_exp", d_exp, 0);
    send(16'd0);
    send(16'd1);
    send(16'd1);
    chk("clr_acc_restart", d_cnt, 1);

    // async reset mid-stream
    do_clr();
    send(16'd0);
    send(16'd1);
    send(16'd1);
    send(16'd2);
    send(16'd3);
    send(16'd5);
    chk("mid_count_before", d_cnt, 4);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_count", d_cnt, 0);
    chk("mid_rst_exp", d_exp, 0);
    chk("mid_rst_locked", d_lock, 0);
    chk("mid_rst_ready", d_rdy, 1);
    #2 rst = 1'b0;
    send(16'd0);
    send(16'd1);
    send(16'd1);
    chk("mid_restart_count", d_cnt, 1);
    chk("mid_restart_locked", d_lock, 1);

    // count saturation on the 4-bit instance: 18 matches, limit 15
    do_clr();
    x0 = 4'd0;
    x1 = 4'd1;
    send({12'd0, x0});
    send({12'd0, x1});
    for (int i = 0; i < 18; i++) begin
      xn = x0 + x1;
      send({12'd0, xn});
      x0 = x1;
      x1 = xn;
      if (i == 13) chk("sat_count_14", w_cnt, 14);
    end
    xn = x0 + x1;
    chk("sat_count", w_cnt, 15);
    chk("sat_locked", w_lock, 1);
    chk("sat_err", w_err, 0);
    chk("sat_exp", w_exp, xn);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
